// File: rtl/regfile_mp_if.sv
// Bundle of the register-file read/write/scoreboard signals between decode,
// writeback and the multi-port register file.
interface regfile_mp_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2
);
   localparam int unsigned AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rd_addr_i;
   logic [NRD*XLEN-1:0] rd_data_o;
   logic [NRD-1:0]      rd_busy_o;
   logic [NWR-1:0]      wr_en_i;
   logic [NWR*AW-1:0]   wr_addr_i;
   logic [NWR*XLEN-1:0] wr_data_i;
   logic                alloc_en_i;
   logic [AW-1:0]       alloc_addr_i;
   logic                flush_i;
   logic [XLEN-1:0]     reg_a0_o;

   modport master (
      output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
      input  rd_data_o, rd_busy_o, reg_a0_o
   );

   modport slave (
      input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
      output rd_data_o, rd_busy_o, reg_a0_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass,
// per-register busy scoreboard and flush.
module regfile_mp #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter bit          BYPASS = 1'b1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);

   logic [XLEN-1:0]     r_regs [NREG];
   logic [NREG-1:0]     r_busy;
   logic [NREG-1:0]     w_busy_nxt;
   logic [NRD*XLEN-1:0] w_rd_data;
   logic [NRD-1:0]      w_rd_busy;

   // Write clears precede alloc so a new producer outranks the retiring one.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (bus.wr_en_i[j]) begin
            w_busy_nxt[bus.wr_addr_i[j*AW +: AW]] = 1'b0;
         end
      end
      if (bus.flush_i) begin
         w_busy_nxt = '0;
      end else if (bus.alloc_en_i) begin
         w_busy_nxt[bus.alloc_addr_i] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Ascending port order makes the highest-index writer win on conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wr_en_i[j] && (bus.wr_addr_i[j*AW +: AW] != '0)) begin
               r_regs[bus.wr_addr_i[j*AW +: AW]] <= bus.wr_data_i[j*XLEN +: XLEN];
            end
         end
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      logic [AW-1:0]   w_addr;
      logic            w_hit;
      logic [XLEN-1:0] w_data;
      w_rd_data = '0;
      w_rd_busy = '0;
      w_addr    = '0;
      w_hit     = 1'b0;
      w_data    = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         w_addr = bus.rd_addr_i[k*AW +: AW];
         w_hit  = 1'b0;
         w_data = r_regs[w_addr];
         if (BYPASS) begin
            for (int unsigned j = 0; j < NWR; j++) begin
               if (bus.wr_en_i[j] && (w_addr != '0) && (bus.wr_addr_i[j*AW +: AW] == w_addr)) begin
                  w_hit  = 1'b1;
                  w_data = bus.wr_data_i[j*XLEN +: XLEN];
               end
            end
         end
         w_rd_data[k*XLEN +: XLEN] = w_data;
         w_rd_busy[k]              = r_busy[w_addr] & ~w_hit;
      end
   end

   // Bypassed write data must not leak out while reset is held.
   assign bus.rd_data_o = rst ? '0 : w_rd_data;
   assign bus.rd_busy_o = rst ? '0 : w_rd_busy;

   generate
      if (NREG > 10) begin : g_a0
         assign bus.reg_a0_o = r_regs[10];
      end else begin : g_no_a0
         assign bus.reg_a0_o = '0;
      end
   endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: one BYPASS=1 and one BYPASS=0
// instance share stimulus and are compared against an array-based model.
module tb_regfile_mp;
   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NRD*AW-1:0]   t_ra = '0;
   logic [NWR-1:0]      t_we = '0;
   logic [NWR*AW-1:0]   t_wa = '0;
   logic [NWR*XLEN-1:0] t_wd = '0;
   logic                t_al = 1'b0;
   logic [AW-1:0]       t_aa = '0;
   logic                t_fl = 1'b0;

   regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus1 ();
   regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus0 ();

   assign bus1.rd_addr_i = t_ra;  assign bus0.rd_addr_i = t_ra;
   assign bus1.wr_en_i   = t_we;  assign bus0.wr_en_i   = t_we;
   assign bus1.wr_addr_i = t_wa;  assign bus0.wr_addr_i = t_wa;
   assign bus1.wr_data_i = t_wd;  assign bus0.wr_data_i = t_wd;
   assign bus1.alloc_en_i   = t_al;  assign bus0.alloc_en_i   = t_al;
   assign bus1.alloc_addr_i = t_aa;  assign bus0.alloc_addr_i = t_aa;
   assign bus1.flush_i   = t_fl;  assign bus0.flush_i   = t_fl;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

   logic [XLEN-1:0] m_reg [NREG];
   logic            m_busy [NREG];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Highest-numbered enabled writer targeting the address supplies the data.
   task automatic exp_read(input int k, input bit byp, output logic [XLEN-1:0] d, output logic b);
      logic [AW-1:0] a;
      logic          hit;
      a   = t_ra[k*AW +: AW];
      hit = 1'b0;
      d   = m_reg[a];
      if (byp && a != 0) begin
         for (int j = NWR - 1; j >= 0; j--) begin
            if (!hit && t_we[j] && t_wa[j*AW +: AW] == a) begin
               hit = 1'b1;
               d   = t_wd[j*XLEN +: XLEN];
            end
         end
      end
      b = m_busy[a] && !hit;
   endtask

   task automatic model_clock();
      logic [AW-1:0] a;
      for (int j = 0; j < NWR; j++) begin
         a = t_wa[j*AW +: AW];
         if (t_we[j] && a != 0) begin
            m_reg[a]  = t_wd[j*XLEN +: XLEN];
            m_busy[a] = 1'b0;
         end
      end
      if (t_fl) begin
         for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else if (t_al && t_aa != 0) begin
         m_busy[t_aa] = 1'b1;
      end
   endtask

   task automatic idle();
      t_we = '0;
      t_al = 1'b0;
      t_fl = 1'b0;
   endtask

   task automatic set_rd(input int k, input logic [AW-1:0] a);
      t_ra[k*AW +: AW] = a;
   endtask

   task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      t_we[j]              = 1'b1;
      t_wa[j*AW +: AW]     = a;
      t_wd[j*XLEN +: XLEN] = d;
   endtask

   task automatic set_alloc(input logic [AW-1:0] a);
      t_al = 1'b1;
      t_aa = a;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
   task automatic cycle(input string tag);
      logic [XLEN-1:0] d;
      logic            b;
      #2;
      for (int k = 0; k < NRD; k++) begin
         exp_read(k, 1'b1, d, b);
         check($sformatf("%s byp1 rd%0d data", tag, k), bus1.rd_data_o[k*XLEN +: XLEN], d);
         check($sformatf("%s byp1 rd%0d busy", tag, k), XLEN'(bus1.rd_busy_o[k]), XLEN'(b));
         exp_read(k, 1'b0, d, b);
         check($sformatf("%s byp0 rd%0d data", tag, k), bus0.rd_data_o[k*XLEN +: XLEN], d);
         check($sformatf("%s byp0 rd%0d busy", tag, k), XLEN'(bus0.rd_busy_o[k]), XLEN'(b));
      end
      check($sformatf("%s byp1 a0", tag), bus1.reg_a0_o, m_reg[10]);
      check($sformatf("%s byp0 a0", tag), bus0.reg_a0_o, m_reg[10]);
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " byp1 data"}, bus1.rd_data_o[XLEN-1:0] | bus1.rd_data_o[2*XLEN-1:XLEN], '0);
      check({tag, " byp0 data"}, bus0.rd_data_o[XLEN-1:0] | bus0.rd_data_o[2*XLEN-1:XLEN], '0);
      check({tag, " busy"}, XLEN'({bus1.rd_busy_o, bus0.rd_busy_o}), '0);
      check({tag, " a0"}, bus1.reg_a0_o | bus0.reg_a0_o, '0);
   endtask

   initial begin
      model_reset();
      set_rd(0, 5'd10);
      set_rd(1, 5'd3);
      set_wr(1, 5'd3, 64'h77);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      idle();
      rst = 1'b0;

      // async reset mid-cycle with a write pending
      set_wr(0, 5'd5, 64'hDEAD);
      cycle("load x5");
      idle();
      set_alloc(5'd8);
      cycle("alloc x8");
      idle();
      set_rd(0, 5'd5);
      set_rd(1, 5'd8);
      set_wr(0, 5'd5, 64'hBEEF);
      #1;
      check("pre-reset x5", bus0.rd_data_o[XLEN-1:0], 64'hDEAD);
      check("pre-reset x8 busy", XLEN'(bus1.rd_busy_o[1]), XLEN'(1));
      rst = 1'b1;
      #1;
      check_all_zero("async reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      idle();
      cycle("post-reset");

      // bypass
      set_rd(0, 5'd7);
      set_wr(0, 5'd7, 64'h1234);
      cycle("bypass wr x7");
      idle();
      cycle("bypass next");

      // write conflict
      set_rd(0, 5'd3);
      set_wr(0, 5'd3, 64'hA);
      set_wr(1, 5'd3, 64'hB);
      cycle("conflict");
      idle();
      cycle("conflict next");

      // scoreboard
      set_rd(1, 5'd9);
      set_alloc(5'd9);
      cycle("alloc x9");
      idle();
      cycle("busy x9");
      set_wr(1, 5'd9, 64'h55);
      cycle("wr x9");
      idle();
      set_alloc(5'd9);
      set_wr(0, 5'd9, 64'h66);
      cycle("alloc+wr x9");
      idle();
      cycle("busy after alloc+wr");

      // register zero
      set_rd(0, 5'd0);
      set_rd(1, 5'd0);
      set_wr(0, 5'd0, 64'hFF);
      set_alloc(5'd0);
      cycle("x0 wr/alloc");
      idle();
      cycle("x0 after");

      // flush
      set_rd(0, 5'd1);
      set_rd(1, 5'd4);
      set_alloc(5'd1); cycle("alloc x1");
      set_alloc(5'd2); cycle("alloc x2");
      set_alloc(5'd4); cycle("alloc x4");
      set_alloc(5'd6); t_fl = 1'b1;
      cycle("flush+alloc x6");
      idle();
      set_rd(0, 5'd6);
      cycle("after flush x6/x4");
      set_rd(0, 5'd1);
      set_rd(1, 5'd2);
      cycle("after flush x1/x2");
      set_rd(0, 5'd10);
      set_wr(1, 5'd10, 64'h42);
      cycle("wr x10");
      idle();
      check("a0 after wr", bus1.reg_a0_o, 64'h42);
      cycle("a0 steady");

      // random traffic, small address window half the time to force collisions
      for (int n = 0; n < 500; n++) begin
         logic [AW-1:0] win;
         win = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
         for (int k = 0; k < NRD; k++) set_rd(k, AW'($urandom_range(0, int'(win))));
         for (int j = 0; j < NWR; j++) begin
            t_we[j]              = ($urandom_range(0, 2) != 0);
            t_wa[j*AW +: AW]     = AW'($urandom_range(0, int'(win)));
            t_wd[j*XLEN +: XLEN] = {$urandom, $urandom};
         end
         t_al = ($urandom_range(0, 1) == 1);
         t_aa = AW'($urandom_range(0, int'(win)));
         t_fl = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
